// File: rtl/viterbi_acs_sched.sv
// Path-metric sequencer for a K=3, rate-1/2 Viterbi decoder (generators 7, 5 octal).
// Time-shares one external combinational ACS unit across the four trellis states:
// each accepted symbol takes four RUN cycles (one per next state) and one COMMIT
// cycle. The commit writes the new bank, with optional MSB normalisation, and
// publishes a registered survivor word.
module viterbi_acs_sched #(
   parameter int PMW     = 8,
   parameter int BMW     = 2,
   parameter bit NORM_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_first,
   input  logic [4*BMW-1:0] bm,
   output logic             acs_p0_valid,
   output logic             acs_p1_valid,
   output logic [BMW-1:0]   acs_p0_bmc,
   output logic [BMW-1:0]   acs_p1_bmc,
   output logic [PMW-1:0]   acs_p0_pmc,
   output logic [PMW-1:0]   acs_p1_pmc,
   input  logic             acs_selection,
   input  logic             acs_valid,
   input  logic [PMW-1:0]   acs_path_cost,
   output logic             surv_valid,
   output logic [3:0]       surv_bits,
   output logic [3:0]       surv_state_valid,
   output logic [1:0]       best_state,
   output logic [PMW-1:0]   best_metric,
   output logic             norm_event
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_COMMIT = 2'd2} state_t;

   localparam logic [PMW-1:0] MSB_MASK = {1'b1, {(PMW-1){1'b0}}};

   // Codeword on the branch from predecessor {ns[0], p_lsb} into ns, with u = ns[1].
   function automatic logic [1:0] branch_cw(input logic [1:0] ns, input logic p_lsb);
      return {ns[1] ^ ns[0] ^ p_lsb, ns[1] ^ p_lsb};
   endfunction

   state_t           state_r, state_s;
   logic [1:0]       idx_r;
   logic [4*BMW-1:0] bm_r;
   logic [PMW-1:0]   pm_r [4];
   logic [3:0]       pv_r;
   logic [PMW-1:0]   npm_r [4];
   logic [3:0]       nv_r;
   logic [3:0]       sbits_r;
   logic [1:0]       cw0_s, cw1_s;
   logic             any_v_s, all_msb_s, norm_s, best_found_s;
   logic [PMW-1:0]   commit_pm_s [4];
   logic [1:0]       best_state_s;
   logic [PMW-1:0]   best_metric_s;
   logic             surv_valid_r, norm_event_r;
   logic [3:0]       surv_bits_r, surv_state_valid_r;
   logic [1:0]       best_state_r;
   logic [PMW-1:0]   best_metric_r;
   logic             accept_s;

   assign in_ready         = (state_r == ST_IDLE);
   assign accept_s         = in_valid && (state_r == ST_IDLE);
   assign surv_valid       = surv_valid_r;
   assign surv_bits        = surv_bits_r;
   assign surv_state_valid = surv_state_valid_r;
   assign best_state       = best_state_r;
   assign best_metric      = best_metric_r;
   assign norm_event       = norm_event_r;

   // Next-state logic: one accept, four ACS evaluations, one commit.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:   if (in_valid) state_s = ST_RUN; else state_s = ST_IDLE;
         ST_RUN:    if (idx_r == 2'd3) state_s = ST_COMMIT; else state_s = ST_RUN;
         ST_COMMIT: state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // State register and next-state index counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         idx_r   <= 2'd0;
      end else begin
         state_r <= state_s;
         if (state_r == ST_RUN) idx_r <= idx_r + 2'd1;
         else                   idx_r <= 2'd0;
      end
   end

   // ACS drive for next state idx: both predecessors share ns[0] as their MSB.
   always_comb begin
      acs_p0_valid = 1'b0;
      acs_p1_valid = 1'b0;
      acs_p0_bmc   = {BMW{1'b0}};
      acs_p1_bmc   = {BMW{1'b0}};
      acs_p0_pmc   = {PMW{1'b0}};
      acs_p1_pmc   = {PMW{1'b0}};
      cw0_s        = branch_cw(idx_r, 1'b0);
      cw1_s        = branch_cw(idx_r, 1'b1);
      if (state_r == ST_RUN) begin
         acs_p0_valid = pv_r[{idx_r[0], 1'b0}];
         acs_p1_valid = pv_r[{idx_r[0], 1'b1}];
         acs_p0_pmc   = pm_r[{idx_r[0], 1'b0}];
         acs_p1_pmc   = pm_r[{idx_r[0], 1'b1}];
         acs_p0_bmc   = bm_r[BMW*cw0_s +: BMW];
         acs_p1_bmc   = bm_r[BMW*cw1_s +: BMW];
      end else begin
         acs_p0_valid = 1'b0;
      end
   end

   // Commit datapath: normalisation, zeroing of invalid states, best-state search.
   always_comb begin
      any_v_s   = |nv_r;
      all_msb_s = 1'b1;
      for (int s = 0; s < 4; s++) begin
         if (nv_r[s] && !npm_r[s][PMW-1]) all_msb_s = 1'b0;
         else                             all_msb_s = all_msb_s;
      end
      norm_s = NORM_EN & any_v_s & all_msb_s;
      for (int s = 0; s < 4; s++) begin
         if (!nv_r[s])    commit_pm_s[s] = {PMW{1'b0}};
         else if (norm_s) commit_pm_s[s] = npm_r[s] & ~MSB_MASK;
         else             commit_pm_s[s] = npm_r[s];
      end
      best_found_s  = 1'b0;
      best_state_s  = 2'd0;
      best_metric_s = {PMW{1'b0}};
      for (int s = 0; s < 4; s++) begin
         if (nv_r[s] && (!best_found_s || commit_pm_s[s] < best_metric_s)) begin
            best_found_s  = 1'b1;
            best_state_s  = 2'(s);
            best_metric_s = commit_pm_s[s];
         end else begin
            best_found_s  = best_found_s;
         end
      end
   end

   // Symbol capture and working path-metric bank (init on first symbol, update at commit).
   always_ff @(posedge clk) begin
      if (rst) begin
         bm_r <= {(4*BMW){1'b0}};
         pv_r <= 4'b0001;
         for (int s = 0; s < 4; s++) pm_r[s] <= {PMW{1'b0}};
      end else begin
         if (accept_s) bm_r <= bm;
         if (accept_s && in_first) begin
            pv_r <= 4'b0001;
            for (int s = 0; s < 4; s++) pm_r[s] <= {PMW{1'b0}};
         end else if (state_r == ST_COMMIT) begin
            pv_r <= nv_r;
            for (int s = 0; s < 4; s++) pm_r[s] <= commit_pm_s[s];
         end
      end
   end

   // Per-next-state capture of the ACS result during RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         nv_r    <= 4'b0000;
         sbits_r <= 4'b0000;
         for (int s = 0; s < 4; s++) npm_r[s] <= {PMW{1'b0}};
      end else if (state_r == ST_RUN) begin
         npm_r[idx_r]   <= acs_path_cost;
         nv_r[idx_r]    <= acs_valid;
         sbits_r[idx_r] <= acs_selection;
      end
   end

   // Registered survivor outputs; pulses last one cycle, the rest hold until the next commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         surv_valid_r       <= 1'b0;
         norm_event_r       <= 1'b0;
         surv_bits_r        <= 4'b0000;
         surv_state_valid_r <= 4'b0000;
         best_state_r       <= 2'd0;
         best_metric_r      <= {PMW{1'b0}};
      end else begin
         surv_valid_r <= (state_r == ST_COMMIT);
         norm_event_r <= (state_r == ST_COMMIT) && norm_s;
         if (state_r == ST_COMMIT) begin
            surv_bits_r        <= sbits_r;
            surv_state_valid_r <= nv_r;
            best_state_r       <= best_state_s;
            best_metric_r      <= best_metric_s;
         end
      end
   end

endmodule

// File: tb/tb_viterbi_acs_sched.sv
// Bench for viterbi_acs_sched: two instances (normalising and free-wrapping) driven
// in lockstep, each with a behavioural ACS, checked against a forward trellis model.
module tb_viterbi_acs_sched;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_first;
   logic [7:0] bm;

   logic       rdy0, p0v0, p1v0, sel0, av0, sv0, ne0;
   logic [1:0] p0b0, p1b0, bs0;
   logic [7:0] p0p0, p1p0, cost0, bmet0;
   logic [3:0] sbits0, ssv0;
   logic       rdy1, p0v1, p1v1, sel1, av1, sv1, ne1;
   logic [1:0] p0b1, p1b1, bs1;
   logic [7:0] p0p1, p1p1, cost1, bmet1;
   logic [3:0] sbits1, ssv1;

   int  n_vec = 0, n_err = 0, n_pulse = 0, np;
   time last_t;
   int  mpm [2][4];
   bit  mv  [2][4];
   int  e_out [2];

   always #5 clk = ~clk;

   // Behavioural ACS: add, compare, select; ties go to predecessor 0.
   function automatic logic [9:0] acs_f(input logic v0, input logic v1, input logic [1:0] b0,
                                        input logic [1:0] b1, input logic [7:0] q0, input logic [7:0] q1);
      logic [7:0] c0, c1;
      c0 = q0 + {6'd0, b0};
      c1 = q1 + {6'd0, b1};
      if (v0 && v1) return (c1 < c0) ? {2'b11, c1} : {2'b10, c0};
      else if (v0)  return {2'b10, c0};
      else if (v1)  return {2'b11, c1};
      else          return 10'd0;
   endfunction

   assign {av0, sel0, cost0} = acs_f(p0v0, p1v0, p0b0, p1b0, p0p0, p1p0);
   assign {av1, sel1, cost1} = acs_f(p0v1, p1v1, p0b1, p1b1, p0p1, p1p1);

   viterbi_acs_sched #(.PMW(8), .BMW(2), .NORM_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_first(in_first), .bm(bm),
      .acs_p0_valid(p0v0), .acs_p1_valid(p1v0), .acs_p0_bmc(p0b0), .acs_p1_bmc(p1b0),
      .acs_p0_pmc(p0p0), .acs_p1_pmc(p1p0), .acs_selection(sel0), .acs_valid(av0),
      .acs_path_cost(cost0), .surv_valid(sv0), .surv_bits(sbits0), .surv_state_valid(ssv0),
      .best_state(bs0), .best_metric(bmet0), .norm_event(ne0));

   viterbi_acs_sched #(.PMW(8), .BMW(2), .NORM_EN(1'b0)) dut_nn (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_first(in_first), .bm(bm),
      .acs_p0_valid(p0v1), .acs_p1_valid(p1v1), .acs_p0_bmc(p0b1), .acs_p1_bmc(p1b1),
      .acs_p0_pmc(p0p1), .acs_p1_pmc(p1p1), .acs_selection(sel1), .acs_valid(av1),
      .acs_path_cost(cost1), .surv_valid(sv1), .surv_bits(sbits1), .surv_state_valid(ssv1),
      .best_state(bs1), .best_metric(bmet1), .norm_event(ne1));

   // Survivor pulse counter (sampled before the edge's updates land).
   always @(posedge clk) if (sv0 === 1'b1) n_pulse++;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Encoder output for register state p = {b1,b0} and input u (generators 7 and 5).
   function automatic int cw(input int p, input int u);
      int b1, b0;
      b1 = (p >> 1) & 1;
      b0 = p & 1;
      return ((u ^ b1 ^ b0) << 1) | (u ^ b0);
   endfunction

   function automatic int bmval(input logic [7:0] bmv, input int c);
      return (int'(bmv) >> (2 * c)) & 3;
   endfunction

   task automatic model_init();
      for (int m = 0; m < 2; m++)
         for (int s = 0; s < 4; s++) begin
            mpm[m][s] = 0;
            mv[m][s]  = (s == 0);
         end
   endtask

   // One trellis step, forward from every valid state over both input bits.
   task automatic model_step(input logic [7:0] bmv);
      for (int m = 0; m < 2; m++) begin
         int nm[4], dec[4], bits, svv, bst, bmet, ne, cost, ns;
         bit nvv[4], anyv, allhi, found;
         for (int s = 0; s < 4; s++) begin nm[s] = 0; dec[s] = 0; nvv[s] = 0; end
         for (int p = 0; p < 4; p++)
            for (int u = 0; u < 2; u++)
               if (mv[m][p]) begin
                  ns   = u * 2 + (p >> 1);
                  cost = (mpm[m][p] + bmval(bmv, cw(p, u))) % 256;
                  if (!nvv[ns] || cost < nm[ns]) begin
                     nm[ns] = cost; nvv[ns] = 1; dec[ns] = p & 1;
                  end
               end
         anyv = 0; allhi = 1;
         for (int s = 0; s < 4; s++) if (nvv[s]) begin anyv = 1; if (nm[s] < 128) allhi = 0; end
         ne = (m == 0 && anyv && allhi) ? 1 : 0;
         bits = 0; svv = 0; bst = 0; bmet = 0; found = 0;
         for (int s = 0; s < 4; s++) begin
            if (!nvv[s]) nm[s] = 0;
            else if (ne == 1) nm[s] = nm[s] - 128;
            bits |= dec[s] << s;
            svv  |= int'(nvv[s]) << s;
            if (nvv[s] && (!found || nm[s] < bmet)) begin found = 1; bst = s; bmet = nm[s]; end
            mpm[m][s] = nm[s];
            mv[m][s]  = nvv[s];
         end
         e_out[m] = (bits << 15) | (svv << 11) | (bst << 9) | (bmet << 1) | ne;
      end
   endtask

   function automatic logic [21:0] exp_drive(input int ns, input logic [7:0] bmv);
      int u, q0, q1;
      u  = ns >> 1;
      q0 = (ns & 1) * 2;
      q1 = q0 + 1;
      return {mv[0][q0], mv[0][q1], 2'(bmval(bmv, cw(q0, u))), 2'(bmval(bmv, cw(q1, u))),
              8'(mpm[0][q0]), 8'(mpm[0][q1])};
   endfunction

   // Offer one symbol, check the four ACS drives, the commit cycle and the survivor word.
   task automatic send(input bit first, input logic [7:0] bmv, input bit hold);
      int  w;
      time t;
      w = 0;
      while (rdy0 !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      chk("ready_before", {63'd0, rdy0}, 64'd1);
      in_valid = 1'b1; in_first = first; bm = bmv;
      if (first) model_init();
      @(posedge clk);
      @(negedge clk);
      if (!hold) in_valid = 1'b0;
      in_first = 1'($urandom);
      bm       = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         chk("acs_drive", {42'd0, p0v0, p1v0, p0b0, p1b0, p0p0, p1p0}, {42'd0, exp_drive(k, bmv)});
         chk("busy", {60'd0, rdy0, rdy1, sv0, sv1}, 64'd0);
      end
      @(negedge clk);
      chk("commit_cycle", {61'd0, rdy0, sv0, ne0}, 64'd0);
      model_step(bmv);
      @(negedge clk);
      chk("surv_pulse", {60'd0, sv0, sv1, rdy0, rdy1}, 64'hF);
      chk("commit_out0", {45'd0, sbits0, ssv0, bs0, bmet0, ne0}, 64'(e_out[0]));
      chk("commit_out1", {45'd0, sbits1, ssv1, bs1, bmet1, ne1}, 64'(e_out[1]));
      t = $time;
      if (hold && last_t != 0) chk("spacing", 64'((t - last_t) / 10), 64'd6);
      last_t = t;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; bm = 8'd0; last_t = 0;
      model_init();
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      // Reset / idle state
      chk("reset_outs", {22'd0, sv0, sbits0, ssv0, bs0, bmet0, ne0, p0v0, p1v0, p0b0, p1b0, p0p0, p1p0}, 64'd0);
      chk("reset_ready", {62'd0, rdy0, rdy1}, 64'd3);

      // First symbol from the known start state
      send(1'b1, 8'b10_01_01_00, 1'b0);
      chk("t2_state_valid", {60'd0, ssv0}, 64'h5);
      chk("t2_bits", {60'd0, sbits0}, 64'h0);
      chk("t2_best", {54'd0, bs0, bmet0}, 64'd0);

      // All branch metrics 1
      send(1'b0, 8'b01_01_01_01, 1'b0);
      chk("t3_state_valid", {60'd0, ssv0}, 64'hF);
      chk("t3_bits", {60'd0, sbits0}, 64'h0);
      chk("t3_best", {54'd0, bs0, bmet0}, 64'd1);

      // Random symbols
      for (int i = 0; i < 30; i++) send(($urandom % 6) == 0, 8'($urandom), 1'b0);

      // Normalisation: metrics climb by 2 per symbol and reach 128 on symbol 64
      for (int i = 0; i < 64; i++) send(i == 0, 8'hAA, 1'b0);
      chk("t4_norm", {55'd0, ne0, bmet0}, {55'd0, 1'b1, 8'd0});
      chk("t4_nonorm", {55'd0, ne1, bmet1}, {55'd0, 1'b0, 8'd128});

      // Back-to-back symbols with in_valid held high
      @(negedge clk);
      np = n_pulse; last_t = 0;
      for (int i = 0; i < 10; i++) send(1'b0, 8'($urandom), 1'b1);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("burst_pulses", 64'(n_pulse - np), 64'd10);

      // Reset during RUN idx=2 abandons the symbol
      np = n_pulse;
      in_valid = 1'b1; in_first = 1'b0; bm = 8'($urandom);
      @(posedge clk);
      @(negedge clk) in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      model_init();
      @(negedge clk);
      chk("post_reset_ready", {61'd0, rdy0, sv0, sv1}, 64'd4);
      chk("post_reset_outs", {45'd0, sbits0, ssv0, bs0, bmet0, ne0}, 64'd0);
      repeat (6) @(negedge clk);
      chk("no_pulse_after_reset", 64'(n_pulse - np), 64'd0);
      send(1'b0, 8'($urandom), 1'b0);
      send(1'b0, 8'($urandom), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
